hazard_unit: RTL and testbench
==============================

# hazard_unit

Pipeline hazard controller for the 5-stage core. It observes the register fields and control bits leaving the ID/EX, EX/MEM and MEM/WB registers and produces the forwarding selects for EX and ID. It also produces the stall and flush controls that drive the IF/ID and ID/EX registers, including the `flushE` bubble input of the ID/EX register. A small FSM holds multi-bubble load-use stalls, and two counters record stall and flush cycles for performance analysis.

## Interface
- `LOAD_BUBBLES`, default 1: bubbles inserted per load-use hazard; legal range 1–3.
- `clk`  in  1: core clock; all state updates on its rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `rsD`, `rtD`  in  5 each: source registers of the instruction in ID.
- `branchD`, `jumpD`  in  1 each: ID holds a conditional branch / a jump.
- `branch_takenD`  in  1: branch comparison in ID resolved as taken.
- `rsE`, `rtE`  in  5 each: source registers of the instruction in EX.
- `writeRegE`, `writeRegM`, `writeRegW`  in  5 each: destination register in EX, MEM, WB.
- `Regfile_weE`, `Regfile_weM`, `Regfile_weW`  in  1 each: register write enable in EX, MEM, WB.
- `regSrc_muxE`, `regSrc_muxM`  in  2 each: writeback source in EX, MEM; 2'b01 = load from data memory.
- `forwardAE`, `forwardBE`  out  2 each: EX operand select; 00 = register file, 01 = WB result, 10 = MEM ALU result.
- `forwardAD`, `forwardBD`  out  1 each: ID branch-compare operand taken from the MEM ALU result.
- `stallF`, `stallD`  out  1 each: hold the PC / hold the IF/ID register.
- `flushD`  out  1: clear the IF/ID register.
- `flushE`  out  1: clear the ID/EX register, inserting a bubble.
- `stall_cnt`, `flush_cnt`  out  32 each: cycles with `stallD`=1 / cycles with `flushD`=1.

## Operation
- A write match requires the stage write enable = 1, the stage write register ≠ 0, and the stage write register equal to the source register.
- `forwardAE` selects from `rsE`:
  - 10 on a MEM write match.
  - Otherwise 01 on a WB write match.
  - Otherwise 00.
  - MEM has priority over WB.
- `forwardBE` uses the same rules on `rtE`.
- `forwardAD` = MEM write match on `rsD` with `regSrc_muxM` ≠ 01; `forwardBD` uses `rtD`.
- Load-use hazard `lwstall`: `regSrc_muxE`=01, `Regfile_weE`=1, `writeRegE`≠0, and `writeRegE` ∈ {`rsD`, `rtD`}.
- Branch hazard `brstall` requires `branchD`=1 and either condition:
  - EX write match on `rsD` or `rtD`.
  - MEM write match on `rsD` or `rtD` with `regSrc_muxM`=01.
- The FSM has two states, RUN and LSTALL, and uses a 2-bit `bcnt`.
  - RUN: `stall` = `lwstall` | `brstall`. If `lwstall` and `LOAD_BUBBLES`>1, go to LSTALL with `bcnt` = `LOAD_BUBBLES`−1.
  - LSTALL: `stall`=1 unconditionally and `bcnt` decrements each cycle. When `bcnt`=1, return to RUN on the next edge.
- `stallF` = `stallD` = `flushE` = `stall`.
- `flushD` = (`jumpD` | (`branchD` & `branch_takenD`)) & ~`stall`. A stalled branch or jump never flushes, because its operands are stale.
- When `flushD` and `stall` would both be asserted, `stall` wins.
- `stall_cnt` increments on every cycle with `stallD`=1; `flush_cnt` increments on every cycle with `flushD`=1. Both wrap modulo 2^32.

## Timing
- Forward, stall and flush outputs are combinational from the inputs and the FSM state, valid within the same cycle.
- The ID/EX and IF/ID registers sample them on the next rising edge.
- A load-use hazard costs exactly `LOAD_BUBBLES` cycles of `stallD`=1 and `LOAD_BUBBLES` bubbles in EX.
- A taken branch or jump costs 1 cycle (`flushD`), asserted in the cycle the branch or jump sits unstalled in ID.
- Reset (`rst`=0, asynchronous) forces:
  - FSM = RUN, `bcnt` = 0, `stall_cnt` = `flush_cnt` = 0.
  - All stall, flush and forward outputs to 0 while `rst` is low, overriding the inputs.
- Reset asserted in LSTALL aborts the stall immediately. After `rst` rises the unit is in RUN.
- A hazard present in the first cycle after reset is detected normally.
- With `writeReg`=0, no forward and no stall occur, even with the write enable at 1.

## Test plan
- EX/MEM forwarding: `rsE`=3, `writeRegM`=3, `Regfile_weM`=1, `writeRegW`=3, `Regfile_weW`=1 -> `forwardAE`=10. Then `Regfile_weM`=0 -> `forwardAE`=01. Then `writeRegW`=0 -> `forwardAE`=00.
- Load-use, `LOAD_BUBBLES`=1: `regSrc_muxE`=01, `Regfile_weE`=1, `writeRegE`=5, `rtD`=5 -> one cycle of `stallF`=`stallD`=`flushE`=1, then 0 once the load has moved to MEM; `stall_cnt`=1.
- Load-use, `LOAD_BUBBLES`=3: same stimulus, with the hazard inputs removed after the first edge -> stall held exactly 3 cycles; `stall_cnt`=3.
- Branch hazard: `branchD`=1, `rsD`=7, `writeRegE`=7, `Regfile_weE`=1, `branch_takenD`=1 -> `stallD`=1 and `flushD`=0. Next cycle, with `writeRegM`=7 and `regSrc_muxM`=00 -> `forwardAD`=1, `flushD`=1, `flush_cnt`=1.
- Jump: `jumpD`=1 with no hazard -> `flushD`=1 for 1 cycle and `stallD`=0. With a simultaneous `lwstall` -> `flushD`=0 and `stallD`=1.
- Reset mid-stall: `LOAD_BUBBLES`=3, assert `rst`=0 in the 2nd stall cycle -> all outputs and counters 0 immediately. After release with no hazard inputs -> `stallD`=0.

Source files
------------

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: EX/ID forwarding selects, load-use and branch stalls,
// jump/branch flush, and stall/flush cycle counters for performance analysis.
module hazard_unit #(
  parameter int LOAD_BUBBLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rsD,
  input  logic [4:0]  rtD,
  input  logic        branchD,
  input  logic        jumpD,
  input  logic        branch_takenD,
  input  logic [4:0]  rsE,
  input  logic [4:0]  rtE,
  input  logic [4:0]  writeRegE,
  input  logic [4:0]  writeRegM,
  input  logic [4:0]  writeRegW,
  input  logic        Regfile_weE,
  input  logic        Regfile_weM,
  input  logic        Regfile_weW,
  input  logic [1:0]  regSrc_muxE,
  input  logic [1:0]  regSrc_muxM,
  output logic [1:0]  forwardAE,
  output logic [1:0]  forwardBE,
  output logic        forwardAD,
  output logic        forwardBD,
  output logic        stallF,
  output logic        stallD,
  output logic        flushD,
  output logic        flushE,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  // state  | meaning
  // RUN    | normal issue; stalls come straight from the hazard detectors
  // LSTALL | extra load-use bubbles pending, bcnt counts those left
  typedef enum logic {RUN = 1'b0, LSTALL = 1'b1} state_t;

  localparam logic [1:0] BCNT_INIT = 2'(LOAD_BUBBLES - 1);
  localparam logic [1:0] SRC_LOAD  = 2'b01;

  state_t      state_q, state_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [31:0] stall_cnt_q, flush_cnt_q;
  logic        stall;
  logic        ex_hit_d, mem_hit_d, lwstall, brstall;

  function automatic logic wmatch(input logic we, input logic [4:0] wr, input logic [4:0] src);
    return we && (wr != 5'd0) && (wr == src);
  endfunction

  assign ex_hit_d  = wmatch(Regfile_weE, writeRegE, rsD) | wmatch(Regfile_weE, writeRegE, rtD);
  assign mem_hit_d = wmatch(Regfile_weM, writeRegM, rsD) | wmatch(Regfile_weM, writeRegM, rtD);
  assign lwstall   = (regSrc_muxE == SRC_LOAD) & ex_hit_d;
  assign brstall   = branchD & (ex_hit_d | ((regSrc_muxM == SRC_LOAD) & mem_hit_d));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      bcnt_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    case (state_q)
      RUN: begin
        if (lwstall && (LOAD_BUBBLES > 1)) begin
          state_d = LSTALL;
          bcnt_d  = BCNT_INIT;
        end
      end
      LSTALL: begin
        bcnt_d = bcnt_q - 2'd1;
        if (bcnt_q == 2'd1) state_d = RUN;
      end
      default: begin
        state_d = RUN;
        bcnt_d  = 2'd0;
      end
    endcase
  end

  // Outputs are forced low while reset is held, regardless of inputs.
  always_comb begin
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    forwardAD = 1'b0;
    forwardBD = 1'b0;
    stall     = 1'b0;
    flushD    = 1'b0;
    if (rst) begin
      if (wmatch(Regfile_weM, writeRegM, rsE))      forwardAE = 2'b10;
      else if (wmatch(Regfile_weW, writeRegW, rsE)) forwardAE = 2'b01;
      if (wmatch(Regfile_weM, writeRegM, rtE))      forwardBE = 2'b10;
      else if (wmatch(Regfile_weW, writeRegW, rtE)) forwardBE = 2'b01;
      forwardAD = wmatch(Regfile_weM, writeRegM, rsD) & (regSrc_muxM != SRC_LOAD);
      forwardBD = wmatch(Regfile_weM, writeRegM, rtD) & (regSrc_muxM != SRC_LOAD);
      stall     = (state_q == LSTALL) | lwstall | brstall;
      flushD    = (jumpD | (branchD & branch_takenD)) & ~stall;
    end
  end

  assign stallF = stall;
  assign stallD = stall;
  assign flushE = stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_q + 32'(stall);
      flush_cnt_q <= flush_cnt_q + 32'(flushD);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: two instances (1 and 3 load bubbles) share stimulus;
// a reference model pushes expectations, a negedge monitor pops and compares.
module tb_hazard_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [4:0] rsD, rtD, rsE, rtE, wrE, wrM, wrW;
    logic       branchD, jumpD, taken, weE, weM, weW;
    logic [1:0] srcE, srcM;
  } vec_t;

  typedef struct {
    logic [1:0]       fAE, fBE;
    logic             fAD, fBD;
    logic [1:0]       stl, fl;
    logic [1:0][31:0] sc, fc;
  } exp_t;

  logic        rst;
  logic [4:0]  rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW;
  logic        branchD, jumpD, branch_takenD, Regfile_weE, Regfile_weM, Regfile_weW;
  logic [1:0]  regSrc_muxE, regSrc_muxM;

  logic [1:0]  fAE1, fBE1, fAE3, fBE3;
  logic        fAD1, fBD1, fAD3, fBD3;
  logic        stF1, stD1, flD1, flE1, stF3, stD3, flD3, flE3;
  logic [31:0] sc1, fc1, sc3, fc3;

  hazard_unit #(.LOAD_BUBBLES(1)) dut1 (
    .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .branchD(branchD), .jumpD(jumpD),
    .branch_takenD(branch_takenD), .rsE(rsE), .rtE(rtE), .writeRegE(writeRegE),
    .writeRegM(writeRegM), .writeRegW(writeRegW), .Regfile_weE(Regfile_weE),
    .Regfile_weM(Regfile_weM), .Regfile_weW(Regfile_weW), .regSrc_muxE(regSrc_muxE),
    .regSrc_muxM(regSrc_muxM), .forwardAE(fAE1), .forwardBE(fBE1), .forwardAD(fAD1),
    .forwardBD(fBD1), .stallF(stF1), .stallD(stD1), .flushD(flD1), .flushE(flE1),
    .stall_cnt(sc1), .flush_cnt(fc1));

  hazard_unit #(.LOAD_BUBBLES(3)) dut3 (
    .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .branchD(branchD), .jumpD(jumpD),
    .branch_takenD(branch_takenD), .rsE(rsE), .rtE(rtE), .writeRegE(writeRegE),
    .writeRegM(writeRegM), .writeRegW(writeRegW), .Regfile_weE(Regfile_weE),
    .Regfile_weM(Regfile_weM), .Regfile_weW(Regfile_weW), .regSrc_muxE(regSrc_muxE),
    .regSrc_muxM(regSrc_muxM), .forwardAE(fAE3), .forwardBE(fBE3), .forwardAD(fAD3),
    .forwardBD(fBD3), .stallF(stF3), .stallD(stD3), .flushD(flD3), .flushE(flE3),
    .stall_cnt(sc3), .flush_cnt(fc3));

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // reference model state, index 0 -> 1 bubble, index 1 -> 3 bubbles
  int          lb[2] = '{1, 3};
  int          rem[2], rem_n[2];
  logic [31:0] m_sc[2], m_fc[2];
  logic        prev_stl[2], prev_fl[2];
  logic        cur_rst;

  function automatic logic wm(input logic we, input logic [4:0] wr, input logic [4:0] src);
    return we && wr != 0 && wr == src;
  endfunction

  function automatic vec_t zero_vec();
    vec_t v;
    v.rst = 1'b1;
    v.rsD = 0; v.rtD = 0; v.rsE = 0; v.rtE = 0; v.wrE = 0; v.wrM = 0; v.wrW = 0;
    v.branchD = 0; v.jumpD = 0; v.taken = 0; v.weE = 0; v.weM = 0; v.weW = 0;
    v.srcE = 0; v.srcM = 0;
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    v.rst     = ($urandom_range(0, 199) != 0);
    v.rsD     = 5'($urandom_range(0, 3));
    v.rtD     = 5'($urandom_range(0, 3));
    v.rsE     = 5'($urandom_range(0, 3));
    v.rtE     = 5'($urandom_range(0, 3));
    v.wrE     = 5'($urandom_range(0, 3));
    v.wrM     = 5'($urandom_range(0, 3));
    v.wrW     = 5'($urandom_range(0, 3));
    v.branchD = 1'($urandom_range(0, 1));
    v.jumpD   = ($urandom_range(0, 3) == 0);
    v.taken   = 1'($urandom_range(0, 1));
    v.weE     = 1'($urandom_range(0, 1));
    v.weM     = 1'($urandom_range(0, 1));
    v.weW     = 1'($urandom_range(0, 1));
    v.srcE    = 2'($urandom_range(0, 3));
    v.srcM    = 2'($urandom_range(0, 3));
    return v;
  endfunction

  task automatic step(input vec_t v);
    exp_t e;
    logic lw, br;
    @(posedge clk);
    #1;
    if (cur_rst) begin
      for (int i = 0; i < 2; i++) begin
        m_sc[i] = m_sc[i] + 32'(prev_stl[i]);
        m_fc[i] = m_fc[i] + 32'(prev_fl[i]);
        rem[i]  = rem_n[i];
      end
    end
    rst = v.rst; rsD = v.rsD; rtD = v.rtD; rsE = v.rsE; rtE = v.rtE;
    writeRegE = v.wrE; writeRegM = v.wrM; writeRegW = v.wrW;
    branchD = v.branchD; jumpD = v.jumpD; branch_takenD = v.taken;
    Regfile_weE = v.weE; Regfile_weM = v.weM; Regfile_weW = v.weW;
    regSrc_muxE = v.srcE; regSrc_muxM = v.srcM;
    cur_rst = v.rst;
    if (!v.rst) begin
      e.fAE = 0; e.fBE = 0; e.fAD = 0; e.fBD = 0;
      for (int i = 0; i < 2; i++) begin
        rem[i] = 0; rem_n[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
        prev_stl[i] = 0; prev_fl[i] = 0;
        e.stl[i] = 0; e.fl[i] = 0; e.sc[i] = 0; e.fc[i] = 0;
      end
    end else begin
      e.fAE = wm(v.weM, v.wrM, v.rsE) ? 2'b10 : wm(v.weW, v.wrW, v.rsE) ? 2'b01 : 2'b00;
      e.fBE = wm(v.weM, v.wrM, v.rtE) ? 2'b10 : wm(v.weW, v.wrW, v.rtE) ? 2'b01 : 2'b00;
      e.fAD = wm(v.weM, v.wrM, v.rsD) && v.srcM != 2'b01;
      e.fBD = wm(v.weM, v.wrM, v.rtD) && v.srcM != 2'b01;
      lw = v.srcE == 2'b01 && v.weE && v.wrE != 0 && (v.wrE == v.rsD || v.wrE == v.rtD);
      br = v.branchD && (wm(v.weE, v.wrE, v.rsD) || wm(v.weE, v.wrE, v.rtD) ||
           (v.srcM == 2'b01 && (wm(v.weM, v.wrM, v.rsD) || wm(v.weM, v.wrM, v.rtD))));
      for (int i = 0; i < 2; i++) begin
        if (rem[i] > 0) begin
          e.stl[i] = 1'b1;
          rem_n[i] = rem[i] - 1;
        end else begin
          e.stl[i] = lw || br;
          rem_n[i] = lw ? lb[i] - 1 : 0;
        end
        e.fl[i] = (v.jumpD || (v.branchD && v.taken)) && !e.stl[i];
        e.sc[i] = m_sc[i];
        e.fc[i] = m_fc[i];
        prev_stl[i] = e.stl[i];
        prev_fl[i]  = e.fl[i];
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("fwdAE_1", 32'(fAE1), 32'(e.fAE));
      chk("fwdBE_1", 32'(fBE1), 32'(e.fBE));
      chk("fwdAD_1", 32'(fAD1), 32'(e.fAD));
      chk("fwdBD_1", 32'(fBD1), 32'(e.fBD));
      chk("fwdAE_3", 32'(fAE3), 32'(e.fAE));
      chk("fwdBE_3", 32'(fBE3), 32'(e.fBE));
      chk("fwdAD_3", 32'(fAD3), 32'(e.fAD));
      chk("fwdBD_3", 32'(fBD3), 32'(e.fBD));
      chk("stallF_1", 32'(stF1), 32'(e.stl[0]));
      chk("stallD_1", 32'(stD1), 32'(e.stl[0]));
      chk("flushE_1", 32'(flE1), 32'(e.stl[0]));
      chk("flushD_1", 32'(flD1), 32'(e.fl[0]));
      chk("stallF_3", 32'(stF3), 32'(e.stl[1]));
      chk("stallD_3", 32'(stD3), 32'(e.stl[1]));
      chk("flushE_3", 32'(flE3), 32'(e.stl[1]));
      chk("flushD_3", 32'(flD3), 32'(e.fl[1]));
      chk("stall_cnt_1", sc1, e.sc[0]);
      chk("flush_cnt_1", fc1, e.fc[0]);
      chk("stall_cnt_3", sc3, e.sc[1]);
      chk("flush_cnt_3", fc3, e.fc[1]);
    end
  end

  initial begin
    vec_t v, z;
    z = zero_vec();
    cur_rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rem[i] = 0; rem_n[i] = 0; m_sc[i] = 0; m_fc[i] = 0; prev_stl[i] = 0; prev_fl[i] = 0;
    end
    v = z; v.rst = 1'b0;
    rst = 1'b0; rsD = 0; rtD = 0; rsE = 0; rtE = 0; writeRegE = 0; writeRegM = 0;
    writeRegW = 0; branchD = 0; jumpD = 0; branch_takenD = 0; Regfile_weE = 0;
    Regfile_weM = 0; Regfile_weW = 0; regSrc_muxE = 0; regSrc_muxM = 0;
    repeat (2) step(v);

    // forwarding priority MEM > WB > none
    v = z; v.rsE = 3; v.wrM = 3; v.weM = 1; v.wrW = 3; v.weW = 1;
    step(v);
    v.weM = 0; step(v);
    v.wrW = 0; step(v);

    // load-use hazard, present for one cycle only
    v = z; v.srcE = 2'b01; v.weE = 1; v.wrE = 5; v.rtD = 5;
    step(v);
    repeat (4) step(z);

    // branch hazard then forwarded branch resolve
    v = z; v.branchD = 1; v.rsD = 7; v.wrE = 7; v.weE = 1; v.taken = 1;
    step(v);
    v = z; v.branchD = 1; v.rsD = 7; v.taken = 1; v.wrM = 7; v.weM = 1; v.srcM = 2'b00;
    step(v);
    step(z);

    // jump alone, then jump with load-use
    v = z; v.jumpD = 1; step(v);
    step(z);
    v = z; v.jumpD = 1; v.srcE = 2'b01; v.weE = 1; v.wrE = 5; v.rsD = 5;
    step(v);
    repeat (3) step(z);

    // zero destination never hazards
    v = z; v.srcE = 2'b01; v.weE = 1; v.wrE = 0; v.branchD = 1; v.weM = 1; v.rsE = 0;
    step(v);

    // reset during the second stall cycle
    v = z; v.srcE = 2'b01; v.weE = 1; v.wrE = 5; v.rtD = 5;
    step(v);
    v = z; v.rst = 1'b0; step(v);
    step(v);
    repeat (3) step(z);

    // randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) step(rand_vec());

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
